// File: rtl/alu_multicycle_if.sv
// Handshake bundle between the decode stage, the multicycle ALU and writeback.
// Operand side: in_valid/in_ready, data1, data2, ALU_Select.
// Result side: out_valid/out_ready, result and the six status flags.
interface alu_multicycle_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [3:0]       ALU_Select;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;
  logic             div_zero;
  logic             illegal;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, data1, data2, ALU_Select, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, negative, div_zero, illegal
  );

  // The ALU itself.
  modport slave (
    input  in_valid, data1, data2, ALU_Select, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, negative, div_zero, illegal
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multicycle ALU: logic/arith/shift/compare in one cycle, iterative MUL/DIVU/REMU at 1 bit/cycle.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH+1 cycles for MUL/DIVU/REMU.
// Backpressure: result and flags held while out_ready=0; in_ready drops while busy or stalled.
// Ports: clk, rst_n (async active-low), bus (alu_multicycle_if.slave: operands in, result/flags out).
module alu_multicycle #(
  parameter int WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_multicycle_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic             in_ready, out_valid, accept, is_iter, last_iter;
  logic [3:0]       op, op_q;
  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   cnt, sh;

  // Iteration registers shared by both algorithms:
  //   MUL : acc = partial product, opa = multiplicand (<<1), opb = multiplier (>>1)
  //   DIV : acc = partial remainder, opa = dividend shifting out / quotient shifting in, opb = divisor
  logic [WIDTH-1:0] acc, opa, opb, acc_n, opa_n, opb_n, iter_res;
  logic [WIDTH:0]   trial;

  logic [WIDTH-1:0] b_x, sc_res;
  logic [WIDTH:0]   sum;
  logic             sc_c, sc_v, sc_dz, sc_ill;

  logic [WIDTH-1:0] res_q;
  logic             zero_q, carry_q, ovf_q, neg_q, dz_q, ill_q;

  assign op        = bus.ALU_Select;
  assign a         = bus.data1;
  assign b         = bus.data2;
  assign sh        = b[SHW-1:0];
  assign accept    = bus.in_valid && in_ready;
  // Divide by zero short-circuits to the single-cycle path.
  assign is_iter   = (op == OP_MUL) || (((op == OP_DIVU) || (op == OP_REMU)) && (b != '0));
  assign last_iter = (cnt == SHW'(WIDTH - 1));

  // Single-cycle datapath, evaluated on the presented operands.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_dz  = 1'b0;
    sc_ill = 1'b0;
    b_x    = (op == OP_SUB) ? ~b : b;
    // SUB is A + ~B + 1, so sum[WIDTH] is the inverted borrow.
    sum    = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    case (op)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_ADD, OP_SUB: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_PASS: sc_res = b;
      OP_NOR:  sc_res = ~(a | b);
      OP_SLL:  sc_res = a << sh;
      OP_SRL:  sc_res = a >> sh;
      OP_SRA:  sc_res = $signed(a) >>> sh;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_DIVU: begin
        sc_res = '1;
        sc_dz  = 1'b1;
      end
      OP_REMU: begin
        sc_res = a;
        sc_dz  = 1'b1;
      end
      OP_MUL:  sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide.
  always_comb begin
    acc_n = acc;
    opa_n = opa;
    opb_n = opb;
    // {acc, next dividend bit} < 2*divisor, so bit WIDTH is a clean sign of the trial subtract.
    trial = {acc, opa[WIDTH-1]} - {1'b0, opb};
    if (op_q == OP_MUL) begin
      acc_n = opb[0] ? (acc + opa) : acc;
      opa_n = opa << 1;
      opb_n = opb >> 1;
    end else if (!trial[WIDTH]) begin
      acc_n = trial[WIDTH-1:0];
      opa_n = {opa[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = {acc[WIDTH-2:0], opa[WIDTH-1]};
      opa_n = {opa[WIDTH-2:0], 1'b0};
    end
    iter_res = (op_q == OP_DIVU) ? opa_n : acc_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_n = is_iter ? BUSY : DONE;
      end
      BUSY: begin
        if (last_iter) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) state_n = is_iter ? BUSY : DONE;
          else              state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      cnt     <= '0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      cnt  <= '0;
      acc  <= '0;
      opa  <= a;
      opb  <= b;
      if (!is_iter) begin
        res_q   <= sc_res;
        zero_q  <= (sc_res == '0);
        carry_q <= sc_c;
        ovf_q   <= sc_v;
        neg_q   <= sc_res[WIDTH-1];
        dz_q    <= sc_dz;
        ill_q   <= sc_ill;
      end
    end else if (state == BUSY) begin
      acc <= acc_n;
      opa <= opa_n;
      opb <= opb_n;
      cnt <= cnt + SHW'(1);
      if (last_iter) begin
        res_q   <= iter_res;
        zero_q  <= (iter_res == '0);
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
        neg_q   <= iter_res[WIDTH-1];
        dz_q    <= 1'b0;
        ill_q   <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.negative  = neg_q;
  assign bus.div_zero  = dz_q;
  assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle at WIDTH=64: directed vectors, randomized ops against a
// reference model, backpressure, back-to-back streaming, busy-ignore and mid-divide reset.
module tb_alu_multicycle;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: {result, zero, carry, overflow, negative, div_zero, illegal}.
  function automatic logic [69:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0]        r;
    logic               c, v, dz, ill;
    logic [64:0]        wide;
    logic signed [65:0] ts;
    r = '0; c = 0; v = 0; dz = 0; ill = 0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[63:0];
        c    = wide[64];
        ts   = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        v    = (ts != $signed({{2{r[63]}}, r}));
      end
      4'd6: begin
        r  = a - b;
        c  = (a >= b);
        ts = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        v  = (ts != $signed({{2{r[63]}}, r}));
      end
      4'd7:  r = b;
      4'd12: r = ~(a | b);
      4'd3:  r = a << b[5:0];
      4'd4:  r = a >> b[5:0];
      4'd5:  r = $signed(a) >>> b[5:0];
      4'd8:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9:  r = (a < b) ? 64'd1 : 64'd0;
      4'd10: r = a * b;
      4'd11: if (b == 0) begin r = '1; dz = 1; end else r = a / b;
      4'd13: if (b == 0) begin r = a;  dz = 1; end else r = a % b;
      default: ill = 1;
    endcase
    return {r, (r == 0), c, v, r[63], dz, ill};
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [63:0] b);
    if (op == 4'd10 || ((op == 4'd11 || op == 4'd13) && b != 0)) return W + 1;
    return 1;
  endfunction

  function automatic logic [69:0] observe();
    return {bus.result, bus.zero, bus.carry, bus.overflow, bus.negative, bus.div_zero, bus.illegal};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bus.ALU_Select = op;
    bus.data1      = a;
    bus.data2      = b;
  endtask

  // Issue one op from IDLE and wait (bounded) for out_valid; leaves result held (out_ready=0).
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output int busy);
    @(negedge clk);
    bus.in_valid = 1'b1;
    drive(op, a, b);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat  = 1;
    busy = 0;
    while (!bus.out_valid && lat < 200) begin
      if (!bus.in_ready) busy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive(4'd0, '0, '0);
    repeat (3) @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    else if (0) ; else ;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) fails++;
    tests++;
    if (observe() !== 70'd0) begin
      fails++;
      $display("FAIL reset_state: got %h required 0", observe());
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  ops  [9] = '{4'd2, 4'd6, 4'd10, 4'd10, 4'd11, 4'd13, 4'd11, 4'd13, 4'd15};
    logic [63:0] as   [9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd3,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 64'd100, 64'd9, 64'd9, 64'd5};
    logic [63:0] bs   [9] = '{64'd1, 64'd1, 64'd5, 64'd2, 64'd7, 64'd7, 64'd0, 64'd0, 64'd3};
    logic [69:0] exps [9] = '{{64'h0, 6'b110000},
                              {64'h7FFF_FFFF_FFFF_FFFF, 6'b011000},
                              {64'd15, 6'b000000},
                              {64'hFFFF_FFFF_FFFF_FFFE, 6'b000100},
                              {64'd14, 6'b000000},
                              {64'd2, 6'b000000},
                              {64'hFFFF_FFFF_FFFF_FFFF, 6'b000110},
                              {64'd9, 6'b000010},
                              {64'd0, 6'b100001}};
    int          lats [9] = '{1, 1, 65, 65, 65, 65, 1, 1, 1};
    int lat, busy;
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], as[i], bs[i], lat, busy);
      tests++;
      if (lat !== lats[i] || busy !== lats[i] - 1) begin
        fails++;
        $display("FAIL directed_lat[%0d]: latency=%0d busy=%0d required %0d/%0d", i, lat, busy, lats[i], lats[i] - 1);
      end
      tests++;
      if (observe() !== exps[i]) begin
        fails++;
        $display("FAIL directed_res[%0d]: got %h required %h", i, observe(), exps[i]);
      end
      drain();
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [63:0] a, b;
    logic [69:0] exp;
    logic [63:0] edges [4] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
    int lat, busy, bad;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 4) == 0) ? edges[$urandom_range(0, 3)] : rnd64();
      case ($urandom_range(0, 3))
        0:       b = 64'($urandom_range(0, 9));
        1:       b = edges[$urandom_range(0, 3)];
        default: b = rnd64();
      endcase
      exp = model(op, a, b);
      run_op(op, a, b, lat, busy);
      tests++;
      if (lat !== model_lat(op, b) || observe() !== exp) begin
        fails++;
        $display("FAIL random[%0d] op=%h a=%h b=%h: got %h lat %0d required %h lat %0d",
                 i, op, a, b, observe(), lat, exp, model_lat(op, b));
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    logic [69:0] snap;
    logic [69:0] exp_or;
    int lat, busy;
    run_op(4'd0, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FF00, lat, busy);
    snap = observe();
    tests++;
    if (snap !== model(4'd0, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FF00)) begin
      fails++;
      $display("FAIL bp_and: got %h", snap);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || observe() !== snap) begin
        fails++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b res=%h required 1/0/%h",
                 i, bus.out_valid, bus.in_ready, observe(), snap);
      end
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive(4'd1, 64'h00FF_0000_0000_0001, 64'h1100_0000_0000_0010);
    exp_or = model(4'd1, 64'h00FF_0000_0000_0001, 64'h1100_0000_0000_0010);
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || observe() !== exp_or) begin
      fails++;
      $display("FAIL bp_next_or: out_valid=%b got %h required 1/%h", bus.out_valid, observe(), exp_or);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  sc_ops [13] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd14, 4'd15};
    logic [3:0]  ops [10];
    logic [63:0] as [10], bs [10];
    logic [69:0] exp;
    for (int i = 0; i < 10; i++) begin
      ops[i] = sc_ops[$urandom_range(0, 12)];
      as[i]  = rnd64();
      bs[i]  = rnd64();
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive(ops[0], as[0], bs[0]);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp = model(ops[i], as[i], bs[i]);
      tests++;
      if (bus.out_valid !== 1'b1 || observe() !== exp) begin
        fails++;
        $display("FAIL b2b[%0d] op=%h: out_valid=%b got %h required %h", i, ops[i], bus.out_valid, observe(), exp);
      end
      if (i < 9) drive(ops[i+1], as[i+1], bs[i+1]);
      else       bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_idle: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, busy;
    @(negedge clk);
    bus.in_valid = 1'b1;
    drive(4'd10, 64'd3, 64'd5);
    @(posedge clk);
    @(negedge clk);
    // Keep presenting a different op while the multiply iterates.
    drive(4'd2, 64'd1, 64'd1);
    lat = 1; busy = 0;
    while (!bus.out_valid && lat < 200) begin
      if (!bus.in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    tests++;
    if (lat !== W + 1 || busy !== W || observe() !== {64'd15, 6'b000000}) begin
      fails++;
      $display("FAIL busy_ignore: lat=%0d busy=%0d got %h required 65/64/%h", lat, busy, observe(), {64'd15, 6'b000000});
    end
    drain();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL busy_ignore_extra: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    bus.in_valid = 1'b1;
    drive(4'd11, 64'd1000, 64'd7);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || observe() !== 70'd0) begin
      fails++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b res=%h required 0/1/0", bus.out_valid, bus.in_ready, observe());
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
    end
    tests++;
    if (seen != 0 || observe() !== 70'd0) begin
      fails++;
      $display("FAIL reset_mid_release: %0d non-idle cycles, res=%h required 0/0", seen, observe());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
